// File: rtl/flap_ctrl.sv
// Player-side round controller: debounces the flap button, sequences IDLE/COUNT/PLAY/OVER,
// and drives registered flap, game_start and a one-tick round_rst towards the bruin block.
module flap_ctrl #(
  parameter int unsigned DEBOUNCE_TICKS  = 2,
  parameter int unsigned COUNTDOWN_TICKS = 15,
  parameter int unsigned FLAP_HOLD       = 1,
  parameter int unsigned OVER_LOCK       = 10
) (
  input  logic       clk_5Hz,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       game_over,
  input  logic       lose,
  output logic       flap,
  output logic       game_start,
  output logic       round_rst,
  output logic [1:0] state,
  output logic [4:0] countdown,
  output logic [7:0] flap_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int unsigned    DBW       = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_TICKS - 1);
  localparam logic [4:0]     CD_INIT   = 5'(COUNTDOWN_TICKS);
  localparam logic [2:0]     HOLD_INIT = 3'(FLAP_HOLD);
  localparam logic [4:0]     LOCK_INIT = 5'(OVER_LOCK);

  logic           s0, s1, btn_db, press;
  logic [DBW-1:0] db_cnt;

  state_t     st, st_n;
  logic [2:0] hold, hold_n;
  logic [4:0] lock, lock_n, cd_n;
  logic [7:0] fc_n;
  logic       flap_n, gs_n, rr_n;

  always_ff @(posedge clk_5Hz or posedge rst) begin
    if (rst) begin
      s0     <= 1'b0;
      s1     <= 1'b0;
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else begin
      s0 <= btn_raw;
      s1 <= s0;
      if (s1 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        btn_db <= s1;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Press fires on the same edge btn_db is accepted high, built only from registered terms.
  always_comb begin
    press = s1 && !btn_db && (db_cnt == DB_LAST);
  end

  always_comb begin
    st_n   = st;
    cd_n   = '0;
    hold_n = hold;
    lock_n = lock;
    fc_n   = flap_count;
    flap_n = 1'b0;
    gs_n   = 1'b0;
    rr_n   = 1'b0;
    case (st)
      IDLE: begin
        if (press) begin
          st_n = COUNT;
          cd_n = CD_INIT;
          fc_n = '0;
        end
      end
      COUNT: begin
        if (countdown == 5'd1) begin
          st_n = PLAY;
          gs_n = 1'b1;
        end else begin
          cd_n = countdown - 5'd1;
        end
      end
      PLAY: begin
        gs_n = 1'b1;
        // A collision outranks a press landing on the same tick.
        if (game_over || lose) begin
          st_n   = OVER;
          gs_n   = 1'b0;
          hold_n = '0;
          lock_n = LOCK_INIT;
        end else if (press) begin
          hold_n = HOLD_INIT;
          flap_n = 1'b1;
          if (flap_count != '1) fc_n = flap_count + 8'd1;
        end else if (hold != '0) begin
          hold_n = hold - 3'd1;
          flap_n = (hold > 3'd1);
        end
      end
      OVER: begin
        if (lock != '0) begin
          lock_n = lock - 5'd1;
        end else if (press) begin
          st_n = IDLE;
          rr_n = 1'b1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_5Hz or posedge rst) begin
    if (rst) begin
      st         <= IDLE;
      hold       <= '0;
      lock       <= '0;
      countdown  <= '0;
      flap_count <= '0;
      flap       <= 1'b0;
      game_start <= 1'b0;
      round_rst  <= 1'b0;
    end else begin
      st         <= st_n;
      hold       <= hold_n;
      lock       <= lock_n;
      countdown  <= cd_n;
      flap_count <= fc_n;
      flap       <= flap_n;
      game_start <= gs_n;
      round_rst  <= rr_n;
    end
  end

  assign state = st;

endmodule
